// File: rtl/race_referee_pkg.sv
// Shared race types: state encodings, winner codes and race-time field layout.
package race_referee_pkg;

    localparam int unsigned TIME_SEC_W = 12;
    localparam int unsigned TIME_MS_W  = 10;
    localparam int unsigned TIME_W     = TIME_SEC_W + TIME_MS_W;
    localparam int unsigned STATE_W    = 2;
    localparam int unsigned WINNER_W   = 2;
    localparam int unsigned POS_W      = 32;
    localparam int unsigned LIGHT_W    = 12;

    localparam logic [TIME_SEC_W-1:0] SEC_MAX = '1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_RACING    = 2'd2,
        ST_FINISHED  = 2'd3
    } race_state_e;

    localparam logic [WINNER_W-1:0] WIN_NONE = 2'd0;
    localparam logic [WINNER_W-1:0] WIN_P1   = 2'd1;
    localparam logic [WINNER_W-1:0] WIN_P2   = 2'd2;
    localparam logic [WINNER_W-1:0] WIN_TIE  = 2'd3;

    typedef struct packed {
        logic [TIME_SEC_W-1:0] sec;
        logic [TIME_MS_W-1:0]  ms;
    } race_time_t;

    // Lower final time wins; identical finals are a tie.
    function automatic logic [WINNER_W-1:0] pick_winner(
        input logic [TIME_W-1:0] a,
        input logic [TIME_W-1:0] b
    );
        if (a < b)      return WIN_P1;
        else if (b < a) return WIN_P2;
        else            return WIN_TIE;
    endfunction

endpackage

// File: rtl/race_referee_time_penalty_add.sv
// Adds the false-start penalty to the seconds field, saturating at the field maximum.
module time_penalty_add
    import race_referee_pkg::*;
#(
    parameter int unsigned PENALTY_S = 1
)
(
    input  race_time_t i_time,
    input  logic       i_penalty,
    output race_time_t o_time_c
);

    logic [32:0] w_sum;

    // Widened add so any penalty value saturates instead of wrapping.
    always_comb begin
        w_sum    = 33'(i_time.sec) + 33'(PENALTY_S);
        o_time_c = i_time;
        if (i_penalty) begin
            if (w_sum > 33'(SEC_MAX)) begin
                o_time_c.sec = SEC_MAX;
            end else begin
                o_time_c.sec = TIME_SEC_W'(w_sum);
            end
        end
    end

endmodule

// File: rtl/race_referee.sv
// Two-player race referee: countdown, false-start tracking, finish latching and winner.
module race_referee
    import race_referee_pkg::*;
#(
    parameter int unsigned FINISH_LINE_POS = 25000,
    parameter int unsigned GO_SECONDS      = 5,
    parameter int unsigned PENALTY_S       = 1
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_game,
    input  logic                restart_tick,
    input  logic [LIGHT_W-1:0]  light_seconds,
    input  logic                p1_throttle,
    input  logic                p2_throttle,
    input  logic [POS_W-1:0]    p1_position,
    input  logic [POS_W-1:0]    p2_position,
    input  logic [TIME_W-1:0]   p1_time,
    input  logic [TIME_W-1:0]   p2_time,
    output logic [STATE_W-1:0]  race_state,
    output logic                go,
    output logic                p1_finished,
    output logic                p2_finished,
    output logic [TIME_W-1:0]   p1_final,
    output logic [TIME_W-1:0]   p2_final,
    output logic [1:0]          false_start,
    output logic [WINNER_W-1:0] winner,
    output logic                race_done
);

    race_state_e         r_state;
    logic                r_go;
    logic                r_p1_finished;
    logic                r_p2_finished;
    logic [TIME_W-1:0]   r_p1_final;
    logic [TIME_W-1:0]   r_p2_final;
    logic [1:0]          r_false_start;
    logic [WINNER_W-1:0] r_winner;
    logic                r_race_done;

    logic                w_to_idle;
    logic                w_go_time;
    logic                w_p1_cross;
    logic                w_p2_cross;
    race_time_t          w_p1_pen;
    race_time_t          w_p2_pen;

    // Penalised finish times, valid whenever a crossing is detected.
    time_penalty_add #(.PENALTY_S(PENALTY_S)) u_p1_pen (
        .i_time    (p1_time),
        .i_penalty (r_false_start[0]),
        .o_time_c  (w_p1_pen)
    );

    time_penalty_add #(.PENALTY_S(PENALTY_S)) u_p2_pen (
        .i_time    (p2_time),
        .i_penalty (r_false_start[1]),
        .o_time_c  (w_p2_pen)
    );

    // Abort conditions and threshold compares.
    always_comb begin
        w_to_idle  = restart_tick || ((r_state != ST_IDLE) && !start_game);
        w_go_time  = (light_seconds >= LIGHT_W'(GO_SECONDS));
        w_p1_cross = (p1_position >= POS_W'(FINISH_LINE_POS));
        w_p2_cross = (p2_position >= POS_W'(FINISH_LINE_POS));
    end

    // Race FSM with registered outputs; any return to IDLE clears all race results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_go          <= 1'b0;
            r_p1_finished <= 1'b0;
            r_p2_finished <= 1'b0;
            r_p1_final    <= '0;
            r_p2_final    <= '0;
            r_false_start <= 2'b00;
            r_winner      <= WIN_NONE;
            r_race_done   <= 1'b0;
        end else if (w_to_idle) begin
            r_state       <= ST_IDLE;
            r_go          <= 1'b0;
            r_p1_finished <= 1'b0;
            r_p2_finished <= 1'b0;
            r_p1_final    <= '0;
            r_p2_final    <= '0;
            r_false_start <= 2'b00;
            r_winner      <= WIN_NONE;
            r_race_done   <= 1'b0;
        end else begin
            r_race_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_game) begin
                        r_state <= ST_COUNTDOWN;
                    end
                end
                ST_COUNTDOWN: begin
                    if (p1_throttle) r_false_start[0] <= 1'b1;
                    if (p2_throttle) r_false_start[1] <= 1'b1;
                    if (w_go_time) begin
                        r_state <= ST_RACING;
                        r_go    <= 1'b1;
                    end
                end
                ST_RACING: begin
                    if (r_p1_finished && r_p2_finished) begin
                        r_state     <= ST_FINISHED;
                        r_go        <= 1'b0;
                        r_race_done <= 1'b1;
                        r_winner    <= pick_winner(r_p1_final, r_p2_final);
                    end else begin
                        if (!r_p1_finished && w_p1_cross) begin
                            r_p1_finished <= 1'b1;
                            r_p1_final    <= w_p1_pen;
                        end
                        if (!r_p2_finished && w_p2_cross) begin
                            r_p2_finished <= 1'b1;
                            r_p2_final    <= w_p2_pen;
                        end
                    end
                end
                ST_FINISHED: begin
                    r_go <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_go    <= 1'b0;
                end
            endcase
        end
    end

    assign race_state  = r_state;
    assign go          = r_go;
    assign p1_finished = r_p1_finished;
    assign p2_finished = r_p2_finished;
    assign p1_final    = r_p1_final;
    assign p2_final    = r_p2_final;
    assign false_start = r_false_start;
    assign winner      = r_winner;
    assign race_done   = r_race_done;

endmodule

// File: tb/tb_race_referee.sv
// Directed self-checking bench for race_referee.
module tb_race_referee;

    logic        clk;
    logic        rst;
    logic        start_game;
    logic        restart_tick;
    logic [11:0] light_seconds;
    logic        p1_throttle;
    logic        p2_throttle;
    logic [31:0] p1_position;
    logic [31:0] p2_position;
    logic [21:0] p1_time;
    logic [21:0] p2_time;
    logic [1:0]  race_state;
    logic        go;
    logic        p1_finished;
    logic        p2_finished;
    logic [21:0] p1_final;
    logic [21:0] p2_final;
    logic [1:0]  false_start;
    logic [1:0]  winner;
    logic        race_done;

    int n_tests = 0;
    int n_fail  = 0;

    race_referee dut (
        .clk           (clk),
        .rst           (rst),
        .start_game    (start_game),
        .restart_tick  (restart_tick),
        .light_seconds (light_seconds),
        .p1_throttle   (p1_throttle),
        .p2_throttle   (p2_throttle),
        .p1_position   (p1_position),
        .p2_position   (p2_position),
        .p1_time       (p1_time),
        .p2_time       (p2_time),
        .race_state    (race_state),
        .go            (go),
        .p1_finished   (p1_finished),
        .p2_finished   (p2_finished),
        .p1_final      (p1_final),
        .p2_final      (p2_final),
        .false_start   (false_start),
        .winner        (winner),
        .race_done     (race_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [21:0] t(input int s, input int ms);
        return {12'(s), 10'(ms)};
    endfunction

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start_game    = 1'b0;
        restart_tick  = 1'b0;
        light_seconds = 12'd0;
        p1_throttle   = 1'b0;
        p2_throttle   = 1'b0;
        p1_position   = 32'd0;
        p2_position   = 32'd0;
        p1_time       = 22'd0;
        p2_time       = 22'd0;
    endtask

    // All outputs bundled so an idle/reset check is a single compare.
    function automatic logic [54:0] all_outs();
        return {race_state, go, p1_finished, p2_finished, p1_final, p2_final,
                false_start, winner, race_done};
    endfunction

    task automatic test_reset();
        #2;
        n_tests++;
        if (all_outs() !== 55'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        n_tests++;
        if (race_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_idle: race_state got %0d expected 0", race_state);
        end
    endtask

    task automatic test_idle_light();
        light_seconds = 12'd9;
        step();
        step();
        n_tests++;
        if (race_state !== 2'd0 || go !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_light: state %0d go %0b expected 0 0", race_state, go);
        end
        clear_inputs();
    endtask

    task automatic test_clean_race();
        start_game = 1'b1;
        step();
        n_tests++;
        if (race_state !== 2'd1 || go !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_countdown: state %0d go %0b expected 1 0", race_state, go);
        end
        light_seconds = 12'd3;
        step();
        n_tests++;
        if (race_state !== 2'd1) begin
            n_fail++;
            $display("FAIL clean_light3: state %0d expected 1", race_state);
        end
        light_seconds = 12'd5;
        step();
        n_tests++;
        if (race_state !== 2'd2 || go !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_racing: state %0d go %0b expected 2 1", race_state, go);
        end
        p1_position = 32'd24999;
        p1_time     = t(3, 240);
        step();
        n_tests++;
        if (p1_finished !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_below_line: p1_finished got %0b expected 0", p1_finished);
        end
        p1_position = 32'd25000;
        p1_time     = t(3, 250);
        step();
        n_tests++;
        if (p1_finished !== 1'b1 || p1_final !== t(3, 250) || p2_finished !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_p1_finish: fin %0b final %h p2fin %0b expected 1 %h 0",
                     p1_finished, p1_final, p2_finished, t(3, 250));
        end
        p1_position = 32'd30000;
        p1_time     = t(3, 260);
        p2_position = 32'd25000;
        p2_time     = t(3, 400);
        step();
        n_tests++;
        if (p2_finished !== 1'b1 || p2_final !== t(3, 400) || p1_final !== t(3, 250)) begin
            n_fail++;
            $display("FAIL clean_p2_finish: p2fin %0b p2final %h p1final %h expected 1 %h %h",
                     p2_finished, p2_final, p1_final, t(3, 400), t(3, 250));
        end
        n_tests++;
        if (race_state !== 2'd2 || race_done !== 1'b0 || winner !== 2'd0) begin
            n_fail++;
            $display("FAIL clean_pre_finish: state %0d done %0b winner %0d expected 2 0 0",
                     race_state, race_done, winner);
        end
        step();
        n_tests++;
        if (race_state !== 2'd3 || race_done !== 1'b1 || winner !== 2'd1 || go !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_finished: state %0d done %0b winner %0d go %0b expected 3 1 1 0",
                     race_state, race_done, winner, go);
        end
        step();
        n_tests++;
        if (race_done !== 1'b0 || winner !== 2'd1 || race_state !== 2'd3) begin
            n_fail++;
            $display("FAIL clean_done_pulse: done %0b winner %0d state %0d expected 0 1 3",
                     race_done, winner, race_state);
        end
        clear_inputs();
        step();
        n_tests++;
        if (all_outs() !== 55'd0) begin
            n_fail++;
            $display("FAIL clean_back_idle: outputs %h expected 0", all_outs());
        end
    endtask

    task automatic test_false_start();
        start_game = 1'b1;
        step();
        light_seconds = 12'd2;
        p2_throttle   = 1'b1;
        step();
        n_tests++;
        if (false_start !== 2'b10) begin
            n_fail++;
            $display("FAIL fs_set: false_start got %b expected 10", false_start);
        end
        p2_throttle = 1'b0;
        step();
        n_tests++;
        if (false_start !== 2'b10) begin
            n_fail++;
            $display("FAIL fs_sticky: false_start got %b expected 10", false_start);
        end
        light_seconds = 12'd5;
        step();
        p2_position = 32'd25000;
        p2_time     = t(3, 100);
        step();
        n_tests++;
        if (p2_finished !== 1'b1 || p2_final !== t(4, 100)) begin
            n_fail++;
            $display("FAIL fs_p2_penalty: fin %0b final %h expected 1 %h",
                     p2_finished, p2_final, t(4, 100));
        end
        p1_position = 32'd25001;
        p1_time     = t(3, 500);
        step();
        n_tests++;
        if (p1_final !== t(3, 500)) begin
            n_fail++;
            $display("FAIL fs_p1_final: got %h expected %h", p1_final, t(3, 500));
        end
        step();
        n_tests++;
        if (race_state !== 2'd3 || winner !== 2'd1 || false_start !== 2'b10) begin
            n_fail++;
            $display("FAIL fs_winner: state %0d winner %0d fs %b expected 3 1 10",
                     race_state, winner, false_start);
        end
        restart_tick = 1'b1;
        start_game   = 1'b0;
        step();
        clear_inputs();
        n_tests++;
        if (all_outs() !== 55'd0) begin
            n_fail++;
            $display("FAIL fs_restart_clear: outputs %h expected 0", all_outs());
        end
    endtask

    task automatic test_simultaneous();
        start_game = 1'b1;
        step();
        light_seconds = 12'd6;
        step();
        p1_position = 32'd25000;
        p2_position = 32'd25000;
        p1_time     = t(2, 999);
        p2_time     = t(2, 999);
        step();
        n_tests++;
        if (p1_finished !== 1'b1 || p2_finished !== 1'b1 ||
            p1_final !== t(2, 999) || p2_final !== t(2, 999)) begin
            n_fail++;
            $display("FAIL sim_both: fin %0b%0b finals %h %h expected 11 %h %h",
                     p1_finished, p2_finished, p1_final, p2_final, t(2, 999), t(2, 999));
        end
        step();
        n_tests++;
        if (race_state !== 2'd3 || winner !== 2'd3 || race_done !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_tie: state %0d winner %0d done %0b expected 3 3 1",
                     race_state, winner, race_done);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_restart_mid_race();
        start_game = 1'b1;
        step();
        light_seconds = 12'd5;
        step();
        p1_position = 32'd26000;
        p1_time     = t(1, 7);
        step();
        n_tests++;
        if (p1_finished !== 1'b1 || race_state !== 2'd2 || go !== 1'b1) begin
            n_fail++;
            $display("FAIL rs_setup: fin %0b state %0d go %0b expected 1 2 1",
                     p1_finished, race_state, go);
        end
        restart_tick = 1'b1;
        step();
        restart_tick = 1'b0;
        p1_position  = 32'd0;
        light_seconds = 12'd0;
        n_tests++;
        if (all_outs() !== 55'd0) begin
            n_fail++;
            $display("FAIL rs_idle: outputs %h expected 0", all_outs());
        end
        step();
        n_tests++;
        if (race_state !== 2'd1) begin
            n_fail++;
            $display("FAIL rs_relaunch: state %0d expected 1", race_state);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_async_reset();
        start_game = 1'b1;
        step();
        light_seconds = 12'd2;
        p1_throttle   = 1'b1;
        step();
        n_tests++;
        if (race_state !== 2'd1 || false_start !== 2'b01) begin
            n_fail++;
            $display("FAIL ar_setup: state %0d fs %b expected 1 01", race_state, false_start);
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (all_outs() !== 55'd0) begin
            n_fail++;
            $display("FAIL ar_immediate: outputs %h expected 0", all_outs());
        end
        #2;
        rst         = 1'b1;
        p1_throttle = 1'b0;
        step();
        n_tests++;
        if (race_state !== 2'd1 || false_start !== 2'b00) begin
            n_fail++;
            $display("FAIL ar_release: state %0d fs %b expected 1 00", race_state, false_start);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_saturation();
        start_game  = 1'b1;
        step();
        p1_throttle = 1'b1;
        step();
        p1_throttle   = 1'b0;
        light_seconds = 12'd5;
        step();
        p1_position = 32'd25000;
        p1_time     = t(4095, 500);
        step();
        n_tests++;
        if (p1_final !== t(4095, 500)) begin
            n_fail++;
            $display("FAIL sat_p1: got %h expected %h", p1_final, t(4095, 500));
        end
        p2_position = 32'd25000;
        p2_time     = t(4095, 0);
        step();
        n_tests++;
        if (p2_final !== t(4095, 0)) begin
            n_fail++;
            $display("FAIL sat_p2_nopen: got %h expected %h", p2_final, t(4095, 0));
        end
        step();
        n_tests++;
        if (winner !== 2'd2) begin
            n_fail++;
            $display("FAIL sat_winner: got %0d expected 2", winner);
        end
        clear_inputs();
        step();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_idle_light();
        test_clean_race();
        test_false_start();
        test_simultaneous();
        test_restart_mid_race();
        test_async_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/race_referee.md
RACE_REFEREE -- requirements
Module: race_referee

Interface
REQ-001 Parameter FINISH_LINE_POS, default 25000: position value at or above which a player has finished.
REQ-002 Parameter GO_SECONDS, default 5: light-timer seconds value that releases the race.
REQ-003 Parameter PENALTY_S, default 1: whole seconds added to the time of a player who false-starts.
REQ-004 clk  input  1  game clock (65 MHz domain); all state changes on its rising edge.
REQ-005 rst  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 start_game  input  1  level; high while the menu has launched a game.
REQ-007 restart_tick  input  1  one-cycle pulse; return to the menu or restart.
REQ-008 light_seconds  input  12  seconds count from the light-signal timer.
REQ-009 p1_throttle, p2_throttle  input  1 each  throttle key levels.
REQ-010 p1_position, p2_position  input  32 each  unsigned distance travelled.
REQ-011 p1_time, p2_time  input  22 each  running race time: [21:10] seconds, [9:0] milliseconds (0..999).
REQ-012 race_state  output  2  0 IDLE, 1 COUNTDOWN, 2 RACING, 3 FINISHED.
REQ-013 go  output  1  high only in RACING; enables controllers and player timers.
REQ-014 p1_finished, p2_finished  output  1 each  sticky finish flags.
REQ-015 p1_final, p2_final  output  22 each  latched final time including penalty.
REQ-016 false_start  output  2  bit0 player 1, bit1 player 2; sticky.
REQ-017 winner  output  2  0 none, 1 player 1, 2 player 2, 3 tie.
REQ-018 race_done  output  1  one-cycle pulse on entry to FINISHED.

Function
REQ-019 IDLE -> COUNTDOWN on the first cycle start_game=1.
REQ-020 COUNTDOWN -> RACING on the first cycle light_seconds >= GO_SECONDS.
REQ-021 In COUNTDOWN, a throttle level of 1 on a player sets that player's false_start bit; the bit cannot be cleared until IDLE.
REQ-022 In RACING, finish detection is registered: pN_finished rises exactly 1 cycle after the first cycle pN_position >= FINISH_LINE_POS.
REQ-023 pN_final is captured in the same cycle pN_finished rises, from pN_time sampled on the detection cycle; further position or time changes are ignored.
REQ-024 Penalty: if false_start bit N is set, pN_final seconds = pN_time[21:10] + PENALTY_S, saturating at 4095; the milliseconds field is unchanged.
REQ-025 Both players crossing in the same cycle: both flags and both finals latch in that same cycle.
REQ-026 RACING -> FINISHED on the cycle after both finished flags are 1; race_done pulses for that one cycle.
REQ-027 On entry to FINISHED, winner is computed by an unsigned compare of the 22-bit finals; lower wins, and equal finals give 3.
REQ-028 winner holds 0 in every state except FINISHED.
REQ-029 go = 1 only in RACING, and go drops in the same cycle RACING is left.
REQ-030 Any state -> IDLE on restart_tick=1, with priority over every other transition.
REQ-031 Any non-IDLE state -> IDLE when start_game=0.
REQ-032 Entering IDLE clears the finished flags, finals, false_start, winner and race_done.
REQ-033 light_seconds values above GO_SECONDS in IDLE have no effect.

Reset
REQ-034 While rst=0, all outputs are 0 and race_state is IDLE, asserted asynchronously.
REQ-035 Reset release mid-game returns the block to IDLE; COUNTDOWN requires start_game to be sampled high afterwards.

Structure
REQ-036 The state encodings, winner codes and time field widths (12 s / 10 ms / 22 total) live in a shared package used by the timers, the scoreboard and race_referee.
REQ-037 One sub-module, time_penalty_add, is combinational: 22-bit time in, penalty flag in, saturated 22-bit time out.
REQ-038 The controller and timer enables in the top level are driven from go and pN_finished instead of local compares.

Verification
REQ-039 Clean race: start_game=1, light_seconds 0->5, p1_position hits 25000 with p1_time 3.250 s, p2 hits 25000 with p2_time 3.400 s -> p1_final=3.250, p2_final=3.400, winner=1, and race_done pulses once.
REQ-040 False start: p2_throttle=1 at light_seconds=2, p2 finishes at 3.100 s and p1 at 3.500 s -> false_start=2'b10, p2_final=4.100, winner=1.
REQ-041 Simultaneous finish: both positions reach 25000 in the same cycle with equal times of 2.999 s -> both flags rise together, winner=3.
REQ-042 Restart mid-race: restart_tick while RACING with p1 finished -> IDLE next cycle, all outputs 0, go=0.
REQ-043 Async reset: rst=0 asserted between clock edges during COUNTDOWN -> outputs 0 immediately; after release with start_game=1 -> COUNTDOWN on the first edge.
REQ-044 Saturation: false start with p1_time seconds = 4095 -> p1_final seconds = 4095.
